load_store_unit: RTL

Initiator side of the data-memory interface for the RISC-V core. Accepts one load or store per handshake from the execute stage and drives the byte-addressed data memory's address, enable, data and byte/word select signals. Checks alignment and range before any access, returns sign- or zero-extended load data, and holds the pipeline via `req_ready` while a transaction is outstanding.

---
 rtl/load_store_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Data-memory initiator for the RV32 core: one load/store per handshake,
// alignment/range checking up front, sign/zero-extended load return.
//
// state  | meaning
// IDLE   | ready for a request; classifies the op on req_valid
// ACCESS | single cycle driving the memory strobes and buses
// DONE   | response held until resp_ready
module load_store_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  output logic                  mem_ls,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  localparam logic [2:0]  F3_BYTE  = 3'b000;
  localparam logic [2:0]  F3_WORD  = 3'b010;
  localparam logic [2:0]  F3_BYTEU = 3'b100;
  localparam logic [31:0] WORD_MAX = 32'((1 << ADDR_WIDTH) - 4);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state, state_nxt;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           resp_data_q;
  logic                  resp_err_q;

  logic                  req_word;
  logic                  req_bad;
  logic [31:0]           load_data;

  always_comb begin
    req_word = (req_funct3 == F3_WORD);
    req_bad  = 1'b0;
    if (req_we)
      req_bad = (req_funct3 != F3_BYTE) && (req_funct3 != F3_WORD);
    else
      req_bad = (req_funct3 != F3_BYTE) && (req_funct3 != F3_WORD) &&
                (req_funct3 != F3_BYTEU);
    if (req_word && (req_addr[1:0] != 2'b00))
      req_bad = 1'b1;
    if (req_addr[31:ADDR_WIDTH] != '0)
      req_bad = 1'b1;
    // Redundant with the two checks above, kept as a guard against edits.
    if (req_word && (req_addr > WORD_MAX))
      req_bad = 1'b1;
  end

  always_comb begin
    case (funct3_q)
      F3_WORD:  load_data = mem_read_data;
      F3_BYTEU: load_data = {24'b0, mem_read_data[7:0]};
      default:  load_data = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'b0;
      resp_data_q <= 32'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          we_q        <= req_we;
          funct3_q    <= req_funct3;
          addr_q      <= req_addr[ADDR_WIDTH-1:0];
          wdata_q     <= req_wdata;
          resp_err_q  <= req_bad;
          resp_data_q <= 32'b0;
        end
        ACCESS: if (!we_q) resp_data_q <= load_data;
        DONE: if (resp_ready) begin
          resp_data_q <= 32'b0;
          resp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt        = state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_ls           = 1'b0;
    mem_write_data   = 32'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_bad ? DONE : ACCESS;
      end
      ACCESS: begin
        mem_address      = addr_q;
        mem_ls           = (funct3_q == F3_WORD);
        mem_write_enable = we_q;
        mem_read_enable  = !we_q;
        if (we_q)
          mem_write_data = (funct3_q == F3_WORD) ? wdata_q : {24'b0, wdata_q[7:0]};
        state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;

endmodule
